// File: rtl/leaf_config_sequencer_pkg.sv
// leaf_config_sequencer_pkg: shared FSM encoding and BFT packet field offsets
package leaf_config_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, SEND, SETTLE, LAUNCH, FIN} state_t;
  localparam int PAYLOAD_LSB = 0;
  localparam int ADDR_LSB    = 32;
  localparam int PORT_LSB    = 41;
  localparam int LEAF_LSB    = 45;
  localparam int VALID_POS   = 48;
endpackage

// File: rtl/leaf_done_collector.sv
// leaf_done_collector: sticky per-leaf done capture compared against the launch mask
module leaf_done_collector #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] leaf_done,
  input  logic [N-1:0] mask,
  output logic         all_done
);
  logic [N-1:0] done_seen_q, done_seen_d;
  // accumulate masked done bits while enabled, drop them on clear
  always_comb done_seen_d = clr ? '0 : en ? (done_seen_q | (leaf_done & mask)) : done_seen_q;
  // done_seen register
  always_ff @(posedge clk)
    if (reset) done_seen_q <= '0;
    else       done_seen_q <= done_seen_d;
  assign all_done = done_seen_q == mask;
endmodule

// File: rtl/leaf_config_sequencer.sv
// leaf_config_sequencer: replays a config packet table into the BFT, then launches and monitors leaves
module leaf_config_sequencer
  import leaf_config_sequencer_pkg::*;
#(
  parameter int NUM_LEAVES    = 8,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 9,
  parameter int PAYLOAD_BITS  = 32,
  parameter int TABLE_DEPTH   = 16,
  parameter int SETTLE_CYCLES = 8,
  localparam int PACKET_BITS  = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  localparam int IDX_BITS     = $clog2(TABLE_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [IDX_BITS:0]      num_entries,
  input  logic [NUM_LEAVES-1:0]  leaf_mask,
  input  logic                   cfg_wr_en,
  input  logic [IDX_BITS-1:0]    cfg_wr_addr,
  input  logic [PACKET_BITS-2:0] cfg_wr_data,
  output logic [PACKET_BITS-1:0] dout_packet,
  input  logic                   resend,
  output logic [NUM_LEAVES-1:0]  ap_start,
  input  logic [NUM_LEAVES-1:0]  leaf_done
);
  localparam int CNT_BITS = $clog2(SETTLE_CYCLES + 1);
  logic [PACKET_BITS-2:0] tbl_q [TABLE_DEPTH];
  state_t                 state_q, state_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [IDX_BITS:0]      num_q, num_d;
  logic [NUM_LEAVES-1:0]  mask_q, mask_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   all_done, last;
  // table is only writable between runs and survives reset
  always_ff @(posedge clk)
    if (cfg_wr_en && state_q == IDLE) tbl_q[cfg_wr_addr] <= cfg_wr_data;
  assign last = (num_q - (IDX_BITS+1)'(1)) == {1'b0, idx_q};
  // next-state logic: latch run parameters, step through table, settle, launch
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        num_d   = num_entries;
        mask_d  = leaf_mask;
        idx_d   = '0;
        state_d = num_entries != '0 ? SEND : SETTLE;
      end
      SEND: if (!resend) begin
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? SETTLE : SEND;
      end
      SETTLE: begin
        cnt_d   = cnt_q == CNT_BITS'(SETTLE_CYCLES - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CNT_BITS'(SETTLE_CYCLES - 1) ? LAUNCH : SETTLE;
      end
      LAUNCH: state_d = all_done ? FIN : LAUNCH;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // run state registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  // packet presented to the BFT only while sending, zero otherwise
  always_comb begin
    dout_packet = '0;
    if (state_q == SEND) begin
      dout_packet[VALID_POS]     = 1'b1;
      dout_packet[VALID_POS-1:0] = tbl_q[idx_q];
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == FIN;
  assign ap_start = state_q == LAUNCH ? mask_q : '0;
  leaf_done_collector #(.N(NUM_LEAVES)) u_collector (
    .clk       (clk),
    .reset     (reset),
    .en        (state_q == LAUNCH),
    .clr       (state_q == FIN),
    .leaf_done (leaf_done),
    .mask      (mask_q),
    .all_done  (all_done)
  );
endmodule

// File: tb/tb_leaf_config_sequencer.sv
// tb_leaf_config_sequencer: directed self-checking bench for leaf_config_sequencer
module tb_leaf_config_sequencer;
  import leaf_config_sequencer_pkg::*;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        busy, done;
  logic [4:0]  num_entries = 0;
  logic [7:0]  leaf_mask = 0;
  logic        cfg_wr_en = 0;
  logic [3:0]  cfg_wr_addr = 0;
  logic [47:0] cfg_wr_data = 0;
  logic [48:0] dout_packet;
  logic        resend = 0;
  logic [7:0]  ap_start;
  logic [7:0]  leaf_done = 0;
  int checks = 0;
  int errors = 0;
  logic [48:0] p0, p1, p2;

  leaf_config_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .num_entries(num_entries), .leaf_mask(leaf_mask),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .dout_packet(dout_packet), .resend(resend), .ap_start(ap_start), .leaf_done(leaf_done)
  );

  always #5 clk = ~clk;

  function automatic logic [48:0] mk(input int leaf, input int port, input int addr, input logic [31:0] pl);
    logic [48:0] p;
    p = '0;
    p[VALID_POS]         = 1'b1;
    p[LEAF_LSB +: 3]     = leaf[2:0];
    p[PORT_LSB +: 4]     = port[3:0];
    p[ADDR_LSB +: 9]     = addr[8:0];
    p[PAYLOAD_LSB +: 32] = pl;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [48:0] p);
    cfg_wr_en = 1; cfg_wr_addr = a[3:0]; cfg_wr_data = p[47:0];
    tick();
    cfg_wr_en = 0;
  endtask

  initial begin
    p0 = mk(2, 0, 'h010, 32'hDEAD_0000);
    p1 = mk(2, 1, 'h011, 32'h1234_5678);
    p2 = mk(5, 0, 'h1FF, 32'hCAFE_F00D);
    tick(); tick();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout_packet, 0);
    chk("rst_ap", ap_start, 0);
    wr(0, p0); wr(1, p1); wr(2, p2);
    // run A: 3 packets, ignored restart, early done ignored, cfg write in LAUNCH ignored
    start = 1; num_entries = 3; leaf_mask = 8'h24;
    tick();
    start = 0;
    chk("a_pkt0", dout_packet, p0);
    chk("a_busy", busy, 1);
    start = 1; num_entries = 0; leaf_mask = 8'h00;
    tick();
    start = 0;
    chk("a_pkt1", dout_packet, p1);
    tick();
    chk("a_pkt2", dout_packet, p2);
    tick();
    chk("a_pkt_end", dout_packet, 0);
    leaf_done = 8'h20;
    tick();
    leaf_done = 0;
    repeat (6) tick();
    chk("a_ap_pre", ap_start, 0);
    tick();
    chk("a_ap_on", ap_start, 8'h24);
    cfg_wr_en = 1; cfg_wr_addr = 0; cfg_wr_data = '1;
    tick();
    cfg_wr_en = 0;
    leaf_done = 8'h05;
    tick();
    leaf_done = 0;
    tick(); tick(); tick();
    leaf_done = 8'h20;
    chk("a_done_early", done, 0);
    tick();
    leaf_done = 0;
    chk("a_done_a5", done, 0);
    chk("a_ap_a5", ap_start, 8'h24);
    tick();
    chk("a_done_a6", done, 1);
    chk("a_ap_a6", ap_start, 0);
    chk("a_busy_a6", busy, 1);
    tick();
    chk("a_busy_a7", busy, 0);
    chk("a_done_a7", done, 0);
    // run B: resend holds entry 1 for three cycles; table readback unchanged
    start = 1; num_entries = 3; leaf_mask = 8'h24;
    tick();
    start = 0;
    chk("b_pkt0", dout_packet, p0);
    tick();
    resend = 1;
    chk("b_pkt1_hold0", dout_packet, p1);
    tick();
    chk("b_pkt1_hold1", dout_packet, p1);
    tick();
    resend = 0;
    chk("b_pkt1_hold2", dout_packet, p1);
    tick();
    chk("b_pkt2", dout_packet, p2);
    tick();
    chk("b_pkt_end", dout_packet, 0);
    repeat (7) tick();
    chk("b_ap_pre", ap_start, 0);
    tick();
    chk("b_ap_on", ap_start, 8'h24);
    leaf_done = 8'h24;
    tick();
    leaf_done = 0;
    chk("b_done_pre", done, 0);
    tick();
    chk("b_done", done, 1);
    tick();
    chk("b_idle", busy, 0);
    // run C: no entries, empty mask
    start = 1; num_entries = 0; leaf_mask = 8'h00;
    tick();
    start = 0;
    chk("c_busy", busy, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("c_dout", dout_packet, 0);
      chk("c_done_wait", done, 0);
      tick();
    end
    chk("c_launch_done", done, 0);
    chk("c_launch_ap", ap_start, 0);
    tick();
    chk("c_done", done, 1);
    tick();
    chk("c_done_off", done, 0);
    chk("c_idle", busy, 0);
    // run D: reset mid-SEND abandons the run, fresh start replays from entry 0
    start = 1; num_entries = 3; leaf_mask = 8'h24;
    tick();
    start = 0;
    chk("d_pkt0", dout_packet, p0);
    tick();
    chk("d_pkt1", dout_packet, p1);
    reset = 1;
    tick();
    reset = 0;
    chk("d_rst_dout", dout_packet, 0);
    chk("d_rst_ap", ap_start, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_done", done, 0);
    start = 1;
    tick();
    start = 0;
    chk("d_re_pkt0", dout_packet, p0);
    tick();
    chk("d_re_pkt1", dout_packet, p1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
